gray_decoder_scan: RTL and testbench
====================================

# gray_decoder_scan

Parametrised, clocked successor to the 4-bit Gray decoding path. It synchronises and debounces a WIDTH-bit Gray-coded switch input and converts the accepted value to binary for the LED bank. It also drives a time-multiplexed multi-digit hex 7-segment display showing either the binary or the raw Gray value. It sits between the board switches and the LED and 7-segment pins at the top level of the FPGA design.

## Interface
- WIDTH, 8, Gray/binary width; multiple of 4, ≥4; NUM_DIGITS = WIDTH/4 (localparam)
- DEBOUNCE, 16, consecutive stable cycles required to accept a new input; ≥2
- REFRESH, 50000, clock cycles each digit stays selected; ≥1
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- gray_in  input  WIDTH  asynchronous Gray-coded switch input
- mode_gray  input  1  asynchronous; 1 = display accepted Gray value, 0 = display binary
- leds  output  WIDTH  accepted value converted to binary, registered
- update  output  1  one-cycle pulse when a new value is accepted
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- an  output  NUM_DIGITS  digit enables, active-low, one-hot-low, registered

## Operation
- Synchroniser: gray_in and mode_gray each pass through two flops, giving sync_q and mode_q.
- Debounce uses a cand register and a cnt counter of width $clog2(DEBOUNCE).
  - If sync_q ≠ cand: cand ← sync_q and cnt ← 0.
  - Else if cnt < DEBOUNCE-1: cnt increments.
  - Else (cnt saturated): if cand ≠ gray_acc, then gray_acc ← cand, leds ← g2b(cand) and update ← 1. Otherwise update ← 0.
- update is high for exactly one cycle per accepted change. It stays low when a stable input equals gray_acc.
- A glitch shorter than DEBOUNCE stable cycles is discarded. The same applies to an input that returns to the old value before acceptance. Neither produces an update.
- g2b conversion: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- Scanner: ref_cnt counts 0..REFRESH-1. On wrap, dig_idx ← (dig_idx+1) mod NUM_DIGITS.
- The displayed nibble is bits [4·dig_idx+3 : 4·dig_idx] of (mode_q ? gray_acc : leds).
- seg ← hex_to_seg(nibble), and an ← all ones with bit dig_idx cleared.
- hex_to_seg patterns:
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Letters: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- If NUM_DIGITS = 1: dig_idx is always 0 and an is constant 0.

## Timing
- Reset values:
  - Synchroniser flops, cand, cnt, gray_acc, leds, ref_cnt and dig_idx are all 0, and update is 0.
  - an = all ones with bit 0 cleared.
  - seg = 1000000 (digit 0 showing "0").
- Acceptance latency: with gray_in changed before edge 0 and held, leds and update change at edge DEBOUNCE+2, i.e. the DEBOUNCE+3rd edge.
- leds and update change on the same edge.
- mode_gray affects seg 3 edges after it changes: 2 sync edges plus 1 output register. It is not debounced.
- seg and an reflect dig_idx and the display value with one cycle of register latency. Each digit is active for exactly REFRESH cycles.
- Reset mid-debounce discards the pending candidate. After release, full latency restarts.
- If the input is 0 at reset release, no update is produced.
- Reset has priority over all other updates.

## Structure
- Package gray_decoder_pkg holds:
  - hex_to_seg function (4-bit → 7-bit) implementing the patterns above
  - SEG_BLANK = 1111111 constant
- Sub-module seg_scan_driver, parametrised by NUM_DIGITS and REFRESH, contains ref_cnt, dig_idx, the nibble mux, hex encoding and the seg/an registers. Its input is a NUM_DIGITS×4 value.
- The top holds the synchronisers, the debounce FSM/counter, g2b (generate loop), mode selection and the leds/update registers.

## Test plan
- Reset: WIDTH=8, rst high 3 cycles → leds=0x00, update=0, an=2'b10, seg=1000000.
- Accept: DEBOUNCE=4, gray_in=0xC0 held → leds=0x80 and update pulse exactly at edge 6 after the change. Then gray_in=0x0F → leds=0x0A with a single pulse.
- Glitch: from accepted 0x00, gray_in=0x0F for 3 cycles then 0x00 (DEBOUNCE=4) → leds stays 0x00, update never asserts.
- Scan: REFRESH=3, leds=0x0A, mode_gray=0 → an=2'b10/seg=0001000 for 3 cycles, then an=2'b01/seg=1000000 for 3 cycles, repeating.
- Mode: gray_acc=0x0F, mode_gray=1 → digit 0 seg=0001110, digit 1 seg=1000000; leds stays 0x0A.
- Reset mid-debounce: change gray_in to 0x0F, assert rst at edge 3 for 1 cycle → leds=0x00. Acceptance occurs DEBOUNCE+3 edges after release, with one update pulse.

Source files
------------

// File: rtl/gray_decoder_pkg.sv
// Shared definitions for the Gray decoder / 7-segment scan block.
// Holds the hex-to-segment encoder and the blank-segment pattern.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package gray_decoder_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex nibble to active-low 7-segment pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver.
// Each digit stays selected for REFRESH cycles, then the next digit is chosen.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   value_i   - NUM_DIGITS nibbles to display, digit 0 in bits [3:0]
//   seg_o     - registered active-low segments {g,f,e,d,c,b,a}
//   an_o      - registered active-low one-hot digit enables
module seg_scan_driver
    import gray_decoder_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned REFRESH    = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*4-1:0] value_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int unsigned REF_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
    logic [DIG_W-1:0]      dig_idx_q, dig_idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            nibble_c;

    // Refresh timer, digit selection, nibble mux and encoding
    always_comb begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        dig_idx_d = dig_idx_q;
        nibble_c  = 4'h0;
        if (ref_cnt_q == REF_W'(REFRESH - 1)) begin
            ref_cnt_d = '0;
            // With a single digit this compare always hits, pinning dig_idx at 0
            dig_idx_d = (dig_idx_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + DIG_W'(1);
        end
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (dig_idx_q == DIG_W'(d)) begin
                nibble_c = value_i[4*d +: 4];
            end
        end
        seg_d = hex_to_seg(nibble_c);
        an_d  = ~(NUM_DIGITS'(1) << dig_idx_q);
    end

    // Scan state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q <= '0;
            dig_idx_q <= '0;
            seg_q     <= hex_to_seg(4'h0);
            an_q      <= ~NUM_DIGITS'(1);
        end else begin
            ref_cnt_q <= ref_cnt_d;
            dig_idx_q <= dig_idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: rtl/gray_decoder_scan.sv
// Synchronises and debounces a Gray-coded switch bank, converts the accepted
// value to binary for the LEDs, and scans it onto a multi-digit hex display.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   gray_in    - asynchronous Gray-coded switch input
//   mode_gray  - asynchronous display select (1 = Gray, 0 = binary)
//   leds       - registered binary value of the accepted input
//   update     - one-cycle pulse when a new value is accepted
//   seg, an    - registered active-low segment and digit-enable outputs
module gray_decoder_scan
    import gray_decoder_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned REFRESH  = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   gray_in,
    input  logic               mode_gray,
    output logic [WIDTH-1:0]   leds,
    output logic               update,
    output logic [6:0]         seg,
    output logic [WIDTH/4-1:0] an
);

    localparam int unsigned NUM_DIGITS = WIDTH / 4;
    localparam int unsigned CNT_W      = $clog2(DEBOUNCE);

    logic [WIDTH-1:0] sync1_q, sync_q;
    logic             mode1_q, mode_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_acc_q, gray_acc_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             update_q, update_d;
    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] disp_c;

    // Two-flop synchronisers for the switch inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync_q  <= '0;
            mode1_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            sync1_q <= gray_in;
            sync_q  <= sync1_q;
            mode1_q <= mode_gray;
            mode_q  <= mode1_q;
        end
    end

    // Gray to binary: each bit is the XOR of all Gray bits at or above it
    for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
        assign bin_c[i] = ^cand_q[WIDTH-1:i];
    end

    // Debounce: restart on any change, accept once the count saturates
    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        gray_acc_d = gray_acc_q;
        leds_d     = leds_q;
        update_d   = 1'b0;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_W'(DEBOUNCE - 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cand_q != gray_acc_q) begin
            gray_acc_d = cand_q;
            leds_d     = bin_c;
            update_d   = 1'b1;
        end
    end

    // Debounce state and LED/update registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q     <= '0;
            cnt_q      <= '0;
            gray_acc_q <= '0;
            leds_q     <= '0;
            update_q   <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            gray_acc_q <= gray_acc_d;
            leds_q     <= leds_d;
            update_q   <= update_d;
        end
    end

    assign disp_c = mode_q ? gray_acc_q : leds_q;

    seg_scan_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH    (REFRESH)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .value_i (disp_c),
        .seg_o   (seg),
        .an_o    (an)
    );

    assign leds   = leds_q;
    assign update = update_q;

endmodule

// File: tb/tb_gray_decoder_scan.sv
// Self-checking bench for gray_decoder_scan (WIDTH=8, DEBOUNCE=4, REFRESH=3).
module tb_gray_decoder_scan;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned REFRESH  = 3;
    localparam int          LAT      = DEBOUNCE + 2;

    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_3 = 7'b0110000;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_6 = 7'b0000010;
    localparam logic [6:0] S_8 = 7'b0000000;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_B = 7'b0000011;
    localparam logic [6:0] S_C = 7'b1000110;
    localparam logic [6:0] S_F = 7'b0001110;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] gray_in;
    logic             mode_gray;
    logic [WIDTH-1:0] leds;
    logic             update;
    logic [6:0]       seg;
    logic [1:0]       an;

    int checks;
    int errors;
    int update_cnt;
    logic [WIDTH-1:0] sb[$];

    typedef struct {
        logic [7:0] gray;
        logic       mode;
        logic [7:0] exp_leds;
        logic [6:0] exp_d0;
        logic [6:0] exp_d1;
    } vec_t;

    vec_t vecs[8];

    gray_decoder_scan #(
        .WIDTH    (WIDTH),
        .DEBOUNCE (DEBOUNCE),
        .REFRESH  (REFRESH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .mode_gray (mode_gray),
        .leds      (leds),
        .update    (update),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Waits for the update pulse after a change driven just after a falling edge
    task automatic wait_accept(output int lat);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // Scoreboard: every update pulse must match the oldest expected LED value
    always @(negedge clk) begin
        if (update === 1'b1) begin
            update_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_update actual=1 required=0 leds=%0h", leds);
            end else begin
                logic [WIDTH-1:0] e;
                e = sb.pop_front();
                if (leds !== e) begin
                    errors++;
                    $display("FAIL leds_on_update actual=%0h required=%0h", leds, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         n10;
        int         found;
        logic [1:0] prev_an;
        logic [7:0] prev_gray;
        int         base;

        checks     = 0;
        errors     = 0;
        update_cnt = 0;

        vecs[0] = '{8'hC0, 1'b0, 8'h80, S_0, S_8};
        vecs[1] = '{8'h0F, 1'b0, 8'h0A, S_A, S_0};
        vecs[2] = '{8'h0F, 1'b1, 8'h0A, S_F, S_0};
        vecs[3] = '{8'h5A, 1'b0, 8'h6C, S_C, S_6};
        vecs[4] = '{8'h5A, 1'b1, 8'h6C, S_A, S_5};
        vecs[5] = '{8'hFF, 1'b0, 8'hAA, S_A, S_A};
        vecs[6] = '{8'h3B, 1'b1, 8'h2D, S_B, S_3};
        vecs[7] = '{8'h00, 1'b0, 8'h00, S_0, S_0};

        // Reset state
        rst       = 1'b1;
        gray_in   = '0;
        mode_gray = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_leds", 32'(leds), 32'h00);
        check("rst_update", 32'(update), 32'h0);
        check("rst_an", 32'(an), 32'h2);
        check("rst_seg", 32'(seg), 32'(S_0));
        rst = 1'b0;

        // Zero input at release must not produce an update
        repeat (10) @(negedge clk);
        check("idle_leds", 32'(leds), 32'h00);
        check("idle_updates", 32'(update_cnt), 32'h0);

        // Table-driven vectors: acceptance latency, LED value and scan pattern
        prev_gray = 8'h00;
        for (int i = 0; i < 8; i++) begin
            gray_in   = vecs[i].gray;
            mode_gray = vecs[i].mode;
            if (vecs[i].gray != prev_gray) begin
                sb.push_back(vecs[i].exp_leds);
                wait_accept(lat);
                check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
                repeat (2) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            check($sformatf("v%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
            n10 = 0;
            for (int s = 0; s < 12; s++) begin
                @(negedge clk);
                if (an == 2'b10) begin
                    n10++;
                    check($sformatf("v%0d_seg_d0", i), 32'(seg), 32'(vecs[i].exp_d0));
                end else begin
                    check($sformatf("v%0d_an", i), 32'(an), 32'h1);
                    check($sformatf("v%0d_seg_d1", i), 32'(seg), 32'(vecs[i].exp_d1));
                end
            end
            check($sformatf("v%0d_dwell_d0", i), 32'(n10), 32'(2 * REFRESH));
            prev_gray = vecs[i].gray;
        end

        // Glitches of 3 and 4 cycles are discarded
        base = update_cnt;
        for (int g = 3; g <= 4; g++) begin
            gray_in = 8'h0F;
            repeat (g) @(negedge clk);
            gray_in = 8'h00;
            repeat (15) @(negedge clk);
            check($sformatf("glitch%0d_leds", g), 32'(leds), 32'h00);
            check($sformatf("glitch%0d_updates", g), 32'(update_cnt), 32'(base));
        end

        // A 5-cycle pulse is just long enough, and so is the return to zero
        sb.push_back(8'h0A);
        gray_in = 8'h0F;
        repeat (5) @(negedge clk);
        gray_in = 8'h00;
        sb.push_back(8'h00);
        repeat (20) @(negedge clk);
        check("pulse5_updates", 32'(update_cnt), 32'(base + 2));
        check("pulse5_leds", 32'(leds), 32'h00);

        // Reset mid-debounce discards the candidate and restarts latency
        mode_gray = 1'b0;
        gray_in   = 8'h0F;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_leds", 32'(leds), 32'h00);
        check("midrst_update", 32'(update), 32'h0);
        check("midrst_an", 32'(an), 32'h2);
        rst = 1'b0;
        sb.push_back(8'h0A);
        wait_accept(lat);
        check("midrst_latency", 32'(lat), 32'(LAT));
        repeat (2) @(negedge clk);

        // Mode switch reaches seg three edges later; dwell is REFRESH samples
        found   = 0;
        prev_an = an;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (prev_an == 2'b10 && an == 2'b01) begin
                found = 1;
                break;
            end
            prev_an = an;
        end
        check("mode_align", 32'(found), 32'h1);
        @(negedge clk);
        mode_gray = 1'b1;
        @(negedge clk);
        check("mode_an_s2", 32'(an), 32'h1);
        @(negedge clk);
        check("mode_an_s3", 32'(an), 32'h2);
        check("mode_seg_old", 32'(seg), 32'(S_A));
        @(negedge clk);
        check("mode_seg_new", 32'(seg), 32'(S_F));
        check("mode_leds", 32'(leds), 32'h0A);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
